// File: rtl/universal_shift_sequencer_if.sv
// Bus bundle for universal_shift_sequencer.
// master: mode, serial ins, data_in, start, count -> q_out, serial outs, busy, done.
// slave:  the opposite directions, used by the sequencer itself.
interface universal_shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [2:0]       mode;
    logic             left_serial_in;
    logic             right_serial_in;
    logic [WIDTH-1:0] data_in;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q_out;
    logic             left_serial_out;
    logic             right_serial_out;
    logic             busy;
    logic             done;

    modport master (
        output mode, left_serial_in, right_serial_in,
        output data_in, start, count,
        input  q_out, left_serial_out, right_serial_out,
        input  busy, done
    );

    modport slave (
        input  mode, left_serial_in, right_serial_in,
        input  data_in, start, count,
        output q_out, left_serial_out, right_serial_out,
        output busy, done
    );
endinterface

// File: rtl/universal_shift_sequencer.sv
// Universal shift register (hold/shift/load/rotate/arith) with a counted
// multi-shift sequencer. Ports: clk, reset (sync, active-high), bus (slave).
module universal_shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    universal_shift_sequencer_if.slave    bus
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_LOAD = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ASR  = 3'b110;

    logic [0:0]       state;
    logic [2:0]       run_mode;
    logic [CNT_W-1:0] remaining;
    logic [WIDTH-1:0] q;
    logic             busy_r;
    logic             done_r;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             lsi,
        input logic             rsi,
        input logic [WIDTH-1:0] din
    );
        logic [WIDTH-1:0] nxt;
        case (op)
            OP_SHR:  nxt = {lsi, cur[WIDTH-1:1]};
            OP_SHL:  nxt = {cur[WIDTH-2:0], rsi};
            OP_LOAD: nxt = din;
            OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
            OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
            OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
            default: nxt = cur;
        endcase
        return nxt;
    endfunction

    // Only modes that actually move bits can be run as a counted sequence.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) ||
               (op == OP_ROL) || (op == OP_ASR);
    endfunction

    logic accept;
    assign accept = bus.start && is_shift(bus.mode) &&
                    (bus.count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            run_mode  <= OP_HOLD;
            remaining <= '0;
            q         <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Accepting edge only latches; shifting starts next edge.
                        run_mode  <= bus.mode;
                        remaining <= bus.count;
                        state     <= RUN;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                    end else begin
                        // Degenerate start still acknowledges with done.
                        q      <= apply_op(bus.mode, q,
                                           bus.left_serial_in,
                                           bus.right_serial_in,
                                           bus.data_in);
                        busy_r <= 1'b0;
                        done_r <= bus.start;
                    end
                end
                default: begin
                    q         <= apply_op(run_mode, q,
                                          bus.left_serial_in,
                                          bus.right_serial_in,
                                          bus.data_in);
                    remaining <= remaining - 1'b1;
                    if (remaining == CNT_W'(1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.q_out            = q;
    assign bus.left_serial_out  = q[WIDTH-1];
    assign bus.right_serial_out = q[0];
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;

endmodule

// File: tb/tb_universal_shift_sequencer.sv
// Self-checking bench for universal_shift_sequencer (WIDTH=8, CNT_W=4).
// Integer-arithmetic reference model plus directed literal checks.
module tb_universal_shift_sequencer;

    localparam int W    = 8;
    localparam int CW   = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int MSB  = 1 << (W - 1);

    logic clk;
    logic reset;
    int   total;
    int   bad;

    universal_shift_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    universal_shift_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour on plain integers.
    function automatic int op_model(input int op, input int v, input int lsi,
                                    input int rsi, input int din);
        case (op)
            1: return (v >> 1) | (lsi * MSB);
            2: return ((v * 2) & MASK) | rsi;
            3: return din & MASK;
            4: return (v >> 1) | ((v % 2) * MSB);
            5: return ((v * 2) & MASK) | (v / MSB);
            6: return (v >> 1) | (v & MSB);
            default: return v;
        endcase
    endfunction

    int mq, mbusy, mdone, mleft, mmode;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq = 0; mbusy = 0; mdone = 0; mleft = 0; mmode = 0;
            model_ok = 1'b1;
        end else if (mleft > 0) begin
            mq = op_model(mmode, mq, int'(bus.left_serial_in),
                          int'(bus.right_serial_in), 0);
            mleft = mleft - 1;
            mbusy = (mleft != 0);
            mdone = (mleft == 0);
        end else if (bus.start && int'(bus.count) != 0 &&
                     int'(bus.mode) inside {1, 2, 4, 5, 6}) begin
            mmode = int'(bus.mode);
            mleft = int'(bus.count);
            mbusy = 1;
            mdone = 0;
        end else begin
            mq = op_model(int'(bus.mode), mq, int'(bus.left_serial_in),
                          int'(bus.right_serial_in), int'(bus.data_in));
            mbusy = 0;
            mdone = int'(bus.start);
        end
        #1;
        if (model_ok) begin
            chk("m_q", int'(bus.q_out), mq);
            chk("m_busy", int'(bus.busy), mbusy);
            chk("m_done", int'(bus.done), mdone);
            chk("m_lso", int'(bus.left_serial_out), (mq >> (W - 1)) & 1);
            chk("m_rso", int'(bus.right_serial_out), mq & 1);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input int mode, input int start, input int count,
                          input int din);
        bus.mode    = 3'(mode);
        bus.start   = 1'(start);
        bus.count   = CW'(count);
        bus.data_in = W'(din);
    endtask

    int nb, nd;
    int qs[16];

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.left_serial_in  = 1'b0;
        bus.right_serial_in = 1'b0;
        set_in(0, 0, 0, 0);

        // Reset held two edges with random control inputs.
        repeat (2) begin
            set_in($urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 15), $urandom_range(0, 255));
            tick();
        end
        chk("rst_q", int'(bus.q_out), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_lso", int'(bus.left_serial_out), 0);
        chk("rst_rso", int'(bus.right_serial_out), 0);
        reset = 1'b0;
        set_in(0, 0, 0, 0);
        tick();
        chk("rel_q", int'(bus.q_out), 'h00);

        // Direct modes.
        set_in(3, 0, 0, 'hA5); tick();
        chk("load_a5", int'(bus.q_out), 'hA5);
        bus.left_serial_in = 1'b1;
        set_in(1, 0, 0, 0); tick();
        chk("shr_d2", int'(bus.q_out), 'hD2);
        bus.right_serial_in = 1'b0;
        set_in(2, 0, 0, 0); tick();
        chk("shl_a4", int'(bus.q_out), 'hA4);
        set_in(7, 0, 0, 0); tick();
        chk("rsv_a4", int'(bus.q_out), 'hA4);

        // Counted rotate right of 81 by 3.
        set_in(3, 0, 0, 'h81); tick();
        set_in(4, 1, 3, 0); tick();
        chk("ror_e0_q", int'(bus.q_out), 'h81);
        set_in(0, 0, 0, 0);
        nb = int'(bus.busy);
        for (int i = 0; i < 5; i++) begin
            tick();
            qs[i] = int'(bus.q_out);
            nb += int'(bus.busy);
            if (i == 2) chk("ror_done", int'(bus.done), 1);
            if (i == 3) chk("ror_done_off", int'(bus.done), 0);
        end
        chk("ror_c0", qs[0], 'hC0);
        chk("ror_60", qs[1], 'h60);
        chk("ror_30", qs[2], 'h30);
        chk("ror_hold", qs[4], 'h30);
        chk("ror_busy_n", nb, 3);

        // Arithmetic shift with a start+load pulsed mid-run.
        set_in(3, 0, 0, 'h90); tick();
        set_in(6, 1, 4, 0); tick();
        set_in(0, 0, 0, 0); tick();
        set_in(3, 1, 2, 'h00); tick();
        set_in(0, 0, 0, 0); tick(); tick();
        chk("asr_f9", int'(bus.q_out), 'hF9);
        chk("asr_done", int'(bus.done), 1);
        tick();

        // Degenerate starts.
        bus.left_serial_in = 1'b0;
        set_in(1, 1, 0, 0); tick();
        chk("cnt0_q", int'(bus.q_out), 'h7C);
        chk("cnt0_done", int'(bus.done), 1);
        chk("cnt0_busy", int'(bus.busy), 0);
        set_in(3, 1, 5, 'h3C); tick();
        chk("ldst_q", int'(bus.q_out), 'h3C);
        chk("ldst_done", int'(bus.done), 1);
        chk("ldst_busy", int'(bus.busy), 0);

        // Start accepted during done cycle: rotate left 3C by 8.
        set_in(5, 1, 8, 0); tick();
        set_in(0, 0, 0, 0);
        nb = int'(bus.busy);
        nd = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            nb += int'(bus.busy);
            nd += int'(bus.done);
        end
        chk("rol8_q", int'(bus.q_out), 'h3C);
        chk("rol8_busy_n", nb, 8);
        chk("rol8_done_n", nd, 1);

        // Reset in the middle of a run.
        set_in(3, 0, 0, 'hFF); tick();
        bus.left_serial_in = 1'b0;
        set_in(1, 1, 5, 0); tick();
        set_in(0, 0, 0, 0); tick(); tick();
        chk("abort_3f", int'(bus.q_out), 'h3F);
        reset = 1'b1; tick();
        reset = 1'b0;
        chk("abort_q", int'(bus.q_out), 0);
        chk("abort_busy", int'(bus.busy), 0);
        nd = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            nd += int'(bus.done);
        end
        chk("abort_no_done", nd, 0);

        // Normal run after the abort: shift left 00 twice with ones.
        bus.right_serial_in = 1'b1;
        set_in(2, 1, 2, 0); tick();
        set_in(0, 0, 0, 0); tick(); tick();
        chk("post_q", int'(bus.q_out), 'h03);
        chk("post_done", int'(bus.done), 1);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
